// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
//   Bundles the signals around the shared-ALU arbiter: two requester
//   channels, two response channels, the ALU drive/return path and the
//   busy flag.
//   Modports:
//     slave  - the arbiter side (accepts requests, drives the ALU, returns results)
//     master - the environment side (requesters, response sinks, ALU model)
interface alu_share_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 3
);
    // Requester 0
    logic              req0_valid_i;
    logic              req0_ready_o;
    logic [CTRL_W-1:0] req0_ctrl_i;
    logic [DATA_W-1:0] req0_data1_i;
    logic [DATA_W-1:0] req0_data2_i;
    // Requester 1
    logic              req1_valid_i;
    logic              req1_ready_o;
    logic [CTRL_W-1:0] req1_ctrl_i;
    logic [DATA_W-1:0] req1_data1_i;
    logic [DATA_W-1:0] req1_data2_i;
    // Responses (data/zero shared by both channels)
    logic              resp0_valid_o;
    logic              resp0_ready_i;
    logic              resp1_valid_o;
    logic              resp1_ready_i;
    logic [DATA_W-1:0] resp_data_o;
    logic              resp_zero_o;
    // External ALU
    logic [DATA_W-1:0] alu_data1_o;
    logic [DATA_W-1:0] alu_data2_o;
    logic [CTRL_W-1:0] alu_ctrl_o;
    logic [DATA_W-1:0] alu_data_i;
    // Status
    logic              busy_o;

    modport slave (
        input  req0_valid_i, req0_ctrl_i, req0_data1_i, req0_data2_i,
        output req0_ready_o,
        input  req1_valid_i, req1_ctrl_i, req1_data1_i, req1_data2_i,
        output req1_ready_o,
        output resp0_valid_o, resp1_valid_o, resp_data_o, resp_zero_o,
        input  resp0_ready_i, resp1_ready_i,
        output alu_data1_o, alu_data2_o, alu_ctrl_o,
        input  alu_data_i,
        output busy_o
    );

    modport master (
        output req0_valid_i, req0_ctrl_i, req0_data1_i, req0_data2_i,
        input  req0_ready_o,
        output req1_valid_i, req1_ctrl_i, req1_data1_i, req1_data2_i,
        input  req1_ready_o,
        input  resp0_valid_o, resp1_valid_o, resp_data_o, resp_zero_o,
        output resp0_ready_i, resp1_ready_i,
        input  alu_data1_o, alu_data2_o, alu_ctrl_o,
        output alu_data_i,
        input  busy_o
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external ALU between two requesters. Arbitration is
//   round-robin in IDLE; the winner's ctrl/operands are latched and held on
//   the ALU inputs for ALU_LAT cycles, then the ALU result and its zero flag
//   are captured and offered to the owning requester until it takes them.
//   Ports:
//     clk_i - clock, rising edge
//     rst_i - asynchronous reset, active-low
//     bus   - requester/response/ALU signal bundle (slave side)
module alu_share_arbiter #(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 3,
    parameter int ALU_LAT = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    alu_share_arbiter_if.slave    bus
);
    localparam int CNT_W = $clog2(ALU_LAT) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic              owner_reg;
    logic              last_grant_reg;
    logic [CTRL_W-1:0] ctrl_reg;
    logic [DATA_W-1:0] data1_reg;
    logic [DATA_W-1:0] data2_reg;
    logic [DATA_W-1:0] resp_data_reg;
    logic              resp_zero_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic grant0;
    logic grant1;
    logic owner_ready;

    // A lone request wins outright; on a tie the side that did not win last
    // time gets the grant.
    always_comb begin
        grant0 = bus.req0_valid_i & (~bus.req1_valid_i | last_grant_reg);
        grant1 = bus.req1_valid_i & (~bus.req0_valid_i | ~last_grant_reg);
    end

    // Only the owner's response ready can retire the result.
    assign owner_ready = owner_reg ? bus.resp1_ready_i : bus.resp0_ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            ctrl_reg       <= '0;
            data1_reg      <= '0;
            data2_reg      <= '0;
            resp_data_reg  <= '0;
            resp_zero_reg  <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // ready equals grant in IDLE, so a grant is a handshake
                    if (grant0) begin
                        ctrl_reg       <= bus.req0_ctrl_i;
                        data1_reg      <= bus.req0_data1_i;
                        data2_reg      <= bus.req0_data2_i;
                        owner_reg      <= 1'b0;
                        last_grant_reg <= 1'b0;
                        cnt_reg        <= CNT_W'(ALU_LAT - 1);
                        state_reg      <= BUSY;
                    end else if (grant1) begin
                        ctrl_reg       <= bus.req1_ctrl_i;
                        data1_reg      <= bus.req1_data1_i;
                        data2_reg      <= bus.req1_data2_i;
                        owner_reg      <= 1'b1;
                        last_grant_reg <= 1'b1;
                        cnt_reg        <= CNT_W'(ALU_LAT - 1);
                        state_reg      <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_reg == '0) begin
                        resp_data_reg <= bus.alu_data_i;
                        resp_zero_reg <= (bus.alu_data_i == '0);
                        state_reg     <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    if (owner_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready_o  = (state_reg == IDLE) & grant0;
    assign bus.req1_ready_o  = (state_reg == IDLE) & grant1;
    assign bus.resp0_valid_o = (state_reg == DONE) & ~owner_reg;
    assign bus.resp1_valid_o = (state_reg == DONE) &  owner_reg;
    assign bus.resp_data_o   = resp_data_reg;
    assign bus.resp_zero_o   = resp_zero_reg;
    assign bus.alu_data1_o   = data1_reg;
    assign bus.alu_data2_o   = data2_reg;
    assign bus.alu_ctrl_o    = ctrl_reg;
    assign bus.busy_o        = (state_reg != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Directed bench for alu_share_arbiter. Instance a uses ALU_LAT=1 with a
//   combinational ALU model; instance b uses ALU_LAT=3 with a two-register
//   pipelined ALU model.
module tb_alu_share_arbiter;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    alu_share_arbiter_if #(.DATA_W(32), .CTRL_W(3)) ifa ();
    alu_share_arbiter_if #(.DATA_W(32), .CTRL_W(3)) ifb ();

    alu_share_arbiter #(.DATA_W(32), .CTRL_W(3), .ALU_LAT(1)) dut_a (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (ifa.slave)
    );

    alu_share_arbiter #(.DATA_W(32), .CTRL_W(3), .ALU_LAT(3)) dut_b (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 3'b011 add, 3'b100 subtract; anything else yields 0
    function automatic logic [31:0] alu_f(logic [2:0] c, logic [31:0] a, logic [31:0] b);
        case (c)
            3'b011:  return a + b;
            3'b100:  return a - b;
            default: return 32'd0;
        endcase
    endfunction

    assign ifa.alu_data_i = alu_f(ifa.alu_ctrl_o, ifa.alu_data1_o, ifa.alu_data2_o);

    logic [31:0] pipe1 = 32'hDEADBEEF;
    logic [31:0] pipe2 = 32'hDEADBEEF;
    always @(posedge clk) begin
        pipe1 <= alu_f(ifb.alu_ctrl_o, ifb.alu_data1_o, ifb.alu_data2_o);
        pipe2 <= pipe1;
    end
    assign ifb.alu_data_i = pipe2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic idle_inputs();
        ifa.req0_valid_i = 1'b0; ifa.req0_ctrl_i = '0; ifa.req0_data1_i = '0; ifa.req0_data2_i = '0;
        ifa.req1_valid_i = 1'b0; ifa.req1_ctrl_i = '0; ifa.req1_data1_i = '0; ifa.req1_data2_i = '0;
        ifa.resp0_ready_i = 1'b1; ifa.resp1_ready_i = 1'b1;
        ifb.req0_valid_i = 1'b0; ifb.req0_ctrl_i = '0; ifb.req0_data1_i = '0; ifb.req0_data2_i = '0;
        ifb.req1_valid_i = 1'b0; ifb.req1_ctrl_i = '0; ifb.req1_data1_i = '0; ifb.req1_data2_i = '0;
        ifb.resp0_ready_i = 1'b1; ifb.resp1_ready_i = 1'b1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        idle_inputs();

        // 1: reset, no requests, five quiet cycles
        do_reset();
        for (int i = 0; i < 5; i++) begin
            check("t1 busy_a",   32'(ifa.busy_o), 32'd0);
            check("t1 rdy_a",    32'({ifa.req0_ready_o, ifa.req1_ready_o}), 32'd0);
            check("t1 rvalid_a", 32'({ifa.resp0_valid_o, ifa.resp1_valid_o}), 32'd0);
            check("t1 alu_a",    ifa.alu_data1_o | ifa.alu_data2_o | 32'(ifa.alu_ctrl_o), 32'd0);
            check("t1 resp_a",   ifa.resp_data_o | 32'(ifa.resp_zero_o), 32'd0);
            check("t1 busy_b",   32'(ifb.busy_o), 32'd0);
            step();
        end

        // 2: single op on req0, ALU_LAT=1, 5+7
        ifa.req0_valid_i = 1'b1; ifa.req0_ctrl_i = 3'b011;
        ifa.req0_data1_i = 32'd5; ifa.req0_data2_i = 32'd7;
        #1;
        check("t2 c0 req0_ready", 32'(ifa.req0_ready_o), 32'd1);
        check("t2 c0 req1_ready", 32'(ifa.req1_ready_o), 32'd0);
        step();
        ifa.req0_valid_i = 1'b0;
        #1;
        check("t2 c1 busy",  32'(ifa.busy_o), 32'd1);
        check("t2 c1 data1", ifa.alu_data1_o, 32'd5);
        check("t2 c1 data2", ifa.alu_data2_o, 32'd7);
        check("t2 c1 ctrl",  32'(ifa.alu_ctrl_o), 32'd3);
        check("t2 c1 rv0",   32'(ifa.resp0_valid_o), 32'd0);
        step();
        check("t2 c2 rv0",   32'(ifa.resp0_valid_o), 32'd1);
        check("t2 c2 rv1",   32'(ifa.resp1_valid_o), 32'd0);
        check("t2 c2 data",  ifa.resp_data_o, 32'd12);
        check("t2 c2 zero",  32'(ifa.resp_zero_o), 32'd0);
        step();
        check("t2 c3 busy",  32'(ifa.busy_o), 32'd0);
        check("t2 c3 rv0",   32'(ifa.resp0_valid_o), 32'd0);

        // 4: ALU_LAT=3 on instance b, req1 9-9 then req0 5+6
        ifb.req1_valid_i = 1'b1; ifb.req1_ctrl_i = 3'b100;
        ifb.req1_data1_i = 32'd9; ifb.req1_data2_i = 32'd9;
        #1;
        check("t4 req1_ready", 32'(ifb.req1_ready_o), 32'd1);
        step();
        ifb.req1_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t4 busy",    32'(ifb.busy_o), 32'd1);
            check("t4 rv1 low", 32'(ifb.resp1_valid_o), 32'd0);
            step();
        end
        check("t4 rv1",  32'(ifb.resp1_valid_o), 32'd1);
        check("t4 rv0",  32'(ifb.resp0_valid_o), 32'd0);
        check("t4 data", ifb.resp_data_o, 32'd0);
        check("t4 zero", 32'(ifb.resp_zero_o), 32'd1);
        step();
        ifb.req0_valid_i = 1'b1; ifb.req0_ctrl_i = 3'b011;
        ifb.req0_data1_i = 32'd5; ifb.req0_data2_i = 32'd6;
        #1;
        check("t4b req0_ready", 32'(ifb.req0_ready_o), 32'd1);
        step();
        ifb.req0_valid_i = 1'b0;
        step();
        step();
        check("t4b pre-capture rv0", 32'(ifb.resp0_valid_o), 32'd0);
        step();
        check("t4b rv0",  32'(ifb.resp0_valid_o), 32'd1);
        check("t4b data", ifb.resp_data_o, 32'd11);
        check("t4b zero", 32'(ifb.resp_zero_o), 32'd0);
        step();

        // 3: both valid continuously, grants alternate starting with req0
        do_reset();
        ifa.req0_valid_i = 1'b1; ifa.req0_ctrl_i = 3'b011; ifa.req0_data1_i = 32'd1; ifa.req0_data2_i = 32'd1;
        ifa.req1_valid_i = 1'b1; ifa.req1_ctrl_i = 3'b011; ifa.req1_data1_i = 32'd2; ifa.req1_data2_i = 32'd2;
        #1;
        for (int i = 0; i < 4; i++) begin
            logic own;
            own = i[0];
            check("t3 grant0", 32'(ifa.req0_ready_o), 32'(!own));
            check("t3 grant1", 32'(ifa.req1_ready_o), 32'(own));
            step();
            check("t3 busy no ready", 32'({ifa.req0_ready_o, ifa.req1_ready_o}), 32'd0);
            step();
            check("t3 rv0",  32'(ifa.resp0_valid_o), 32'(!own));
            check("t3 rv1",  32'(ifa.resp1_valid_o), 32'(own));
            check("t3 data", ifa.resp_data_o, own ? 32'd4 : 32'd2);
            step();
        end
        ifa.req0_valid_i = 1'b0;
        ifa.req1_valid_i = 1'b0;

        // 5: response backpressure on req0 while req1 waits
        do_reset();
        ifa.resp0_ready_i = 1'b0;
        ifa.req0_valid_i = 1'b1; ifa.req0_data1_i = 32'd1; ifa.req0_data2_i = 32'd1;
        #1;
        check("t5 req0_ready", 32'(ifa.req0_ready_o), 32'd1);
        step();
        ifa.req0_valid_i = 1'b0;
        ifa.req1_valid_i = 1'b1; ifa.req1_data1_i = 32'd2; ifa.req1_data2_i = 32'd2;
        #1;
        check("t5 busy req1_ready", 32'(ifa.req1_ready_o), 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            check("t5 hold rv0",  32'(ifa.resp0_valid_o), 32'd1);
            check("t5 hold data", ifa.resp_data_o, 32'd2);
            check("t5 hold rdy1", 32'(ifa.req1_ready_o), 32'd0);
            step();
        end
        ifa.resp1_ready_i = 1'b1;
        ifa.resp0_ready_i = 1'b1;
        #1;
        check("t5 hs rdy1", 32'(ifa.req1_ready_o), 32'd0);
        check("t5 hs rv0",  32'(ifa.resp0_valid_o), 32'd1);
        step();
        check("t5 after hs rdy1", 32'(ifa.req1_ready_o), 32'd1);
        step();
        ifa.req1_valid_i = 1'b0;
        check("t5 req1 data1", ifa.alu_data1_o, 32'd2);
        step();
        check("t5 rv1",  32'(ifa.resp1_valid_o), 32'd1);
        check("t5 data", ifa.resp_data_o, 32'd4);
        step();

        // 6: reset during BUSY abandons the operation
        ifa.req0_valid_i = 1'b1; ifa.req0_data1_i = 32'd3; ifa.req0_data2_i = 32'd4;
        step();
        ifa.req0_valid_i = 1'b0;
        #1;
        check("t6 busy before rst", 32'(ifa.busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6 rst busy",  32'(ifa.busy_o), 32'd0);
        check("t6 rst alu",   ifa.alu_data1_o | ifa.alu_data2_o, 32'd0);
        check("t6 rst resp",  ifa.resp_data_o, 32'd0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6 no resp", 32'({ifa.resp0_valid_o, ifa.resp1_valid_o}), 32'd0);
        end
        ifa.req0_valid_i = 1'b1;
        ifa.req1_valid_i = 1'b1;
        #1;
        check("t6 tie grant0", 32'(ifa.req0_ready_o), 32'd1);
        check("t6 tie grant1", 32'(ifa.req1_ready_o), 32'd0);
        ifa.req0_valid_i = 1'b0;
        ifa.req1_valid_i = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
